// File: rtl/selector_pkg.sv
// -----------------------------------------------------------------------------
// selector_pkg
// Shared types and helpers for the condition-test selector.
//   estado_t       : FSM state of the selector (IDLE / ESPERA).
//   cod_constante  : first test code that selects the auxiliary constant 0.
// -----------------------------------------------------------------------------
package selector_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ESPERA = 1'b1
  } estado_t;

  // Codes 0..n_cond-1 pick a condition and code n_cond picks the pending
  // interrupt, so every code from n_cond+1 upwards reads as constant 0.
  function automatic int cod_constante(input int n_cond);
    return n_cond + 1;
  endfunction

endpackage

// File: rtl/selector_prueba_sincronizador.sv
// -----------------------------------------------------------------------------
// sincronizador
// Multi-flop synchroniser for a bus of independent asynchronous level inputs.
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset, clears every stage
//   d      : asynchronous inputs (WIDTH bits)
//   q      : synchronised outputs, d delayed by STAGES rising edges
// -----------------------------------------------------------------------------
module sincronizador #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Index 0 is the first flop and index STAGES-1 feeds the output.
  logic [STAGES-1:0][WIDTH-1:0] etapas;

  // NOTE: clocked state uses non-blocking assignments so that every stage
  // samples the value its predecessor held before the edge. Blocking
  // assignments here would collapse the chain into a single flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      etapas <= '0;
    end else begin
      etapas <= {etapas[STAGES-2:0], d};
    end
  end

  assign q = etapas[STAGES-1];

endmodule

// File: rtl/selector_prueba.sv
// -----------------------------------------------------------------------------
// selector_prueba
// Condition-test selector for the microprogrammed control unit. It
// synchronises the condition flags and the interrupt line, latches interrupt
// requests until they are acknowledged, and answers sequencer test requests
// either as a single-shot evaluation or as a bounded wait-until-true.
//   clk, rst_n     : clock (rising edge) and asynchronous active-low reset
//   condiciones    : asynchronous condition flags, bit i answers code i
//   interrupcion   : asynchronous interrupt request (level)
//   prueba         : test code (conditions, then pending flag, then constant 0)
//   invertir       : invert the selected value
//   evaluar        : one-cycle test request strobe
//   modo_espera    : 0 = single shot, 1 = wait until true
//   limite         : wait mode limit (limite+1 checks at most)
//   ack_int        : clears the interrupt-pending flag
//   qseleccionada  : registered test result, held until the next result
//   valido         : one-cycle pulse marking a new result
//   ocupado        : high while a wait test is running
//   expirado       : registered with the result, 1 when a wait timed out
//   int_pendiente  : latched interrupt-pending flag
// -----------------------------------------------------------------------------
module selector_prueba #(
  parameter int N_COND      = 3,
  parameter int SEL_W       = 3,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_COND-1:0]    condiciones,
  input  logic                 interrupcion,
  input  logic [SEL_W-1:0]     prueba,
  input  logic                 invertir,
  input  logic                 evaluar,
  input  logic                 modo_espera,
  input  logic [TIMEOUT_W-1:0] limite,
  input  logic                 ack_int,
  output logic                 qseleccionada,
  output logic                 valido,
  output logic                 ocupado,
  output logic                 expirado,
  output logic                 int_pendiente
);

  import selector_pkg::*;

  localparam logic [SEL_W-1:0] COD_INT   = SEL_W'(N_COND);
  localparam logic [SEL_W-1:0] COD_CONST = SEL_W'(cod_constante(N_COND));

  // ---------------------------------------------------------------------------
  // Synchronisers: conditions and interrupt share one instance.
  // ---------------------------------------------------------------------------
  logic [N_COND:0]   crudo;
  logic [N_COND:0]   sinc;
  logic [N_COND-1:0] cond_s;
  logic              int_s;

  assign crudo = {interrupcion, condiciones};

  sincronizador #(
    .WIDTH  (N_COND + 1),
    .STAGES (SYNC_STAGES)
  ) u_sincronizador (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (crudo),
    .q     (sinc)
  );

  assign cond_s = sinc[N_COND-1:0];
  assign int_s  = sinc[N_COND];

  // ---------------------------------------------------------------------------
  // Interrupt edge detect and pending latch. A new rising edge wins over an
  // acknowledge in the same cycle so that no request is lost.
  // ---------------------------------------------------------------------------
  logic int_prev;
  logic int_subida;

  assign int_subida = int_s & ~int_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int_prev      <= 1'b0;
      int_pendiente <= 1'b0;
    end else begin
      int_prev <= int_s;
      if (int_subida) begin
        int_pendiente <= 1'b1;
      end else if (ack_int) begin
        int_pendiente <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Select / invert mux. Constant codes read 0 before inversion, so with
  // invertir set they answer 1.
  // ---------------------------------------------------------------------------
  function automatic logic valor_sel(
    input logic [SEL_W-1:0]  codigo,
    input logic              inv,
    input logic [N_COND-1:0] conds,
    input logic              pend
  );
    logic v;
    v = 1'b0;
    if (codigo >= COD_CONST) begin
      v = 1'b0;
    end else if (codigo == COD_INT) begin
      v = pend;
    end else begin
      for (int i = 0; i < N_COND; i++) begin
        if (codigo == SEL_W'(i)) v = conds[i];
      end
    end
    return v ^ inv;
  endfunction

  // ---------------------------------------------------------------------------
  // FSM and down-counter. A wait test uses the code and inversion captured at
  // the request, not the live inputs.
  // ---------------------------------------------------------------------------
  estado_t              estado, estado_d;
  logic [SEL_W-1:0]     cod_q, cod_d;
  logic                 inv_q, inv_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic                 q_d, valido_d, exp_d;
  logic                 s_directo, s_espera;

  assign s_directo = valor_sel(prueba, invertir, cond_s, int_pendiente);
  assign s_espera  = valor_sel(cod_q, inv_q, cond_s, int_pendiente);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado        <= IDLE;
      cod_q         <= '0;
      inv_q         <= 1'b0;
      cnt_q         <= '0;
      qseleccionada <= 1'b0;
      valido        <= 1'b0;
      expirado      <= 1'b0;
    end else begin
      estado        <= estado_d;
      cod_q         <= cod_d;
      inv_q         <= inv_d;
      cnt_q         <= cnt_d;
      qseleccionada <= q_d;
      valido        <= valido_d;
      expirado      <= exp_d;
    end
  end

  // NOTE: every signal written here gets a default before the case statement.
  // Leaving any path without an assignment would infer a latch.
  always_comb begin
    estado_d = estado;
    cod_d    = cod_q;
    inv_d    = inv_q;
    cnt_d    = cnt_q;
    q_d      = qseleccionada;
    valido_d = 1'b0;
    exp_d    = expirado;

    case (estado)
      IDLE: begin
        if (evaluar) begin
          if (!modo_espera) begin
            q_d      = s_directo;
            valido_d = 1'b1;
            exp_d    = 1'b0;
          end else begin
            cod_d    = prueba;
            inv_d    = invertir;
            cnt_d    = limite;
            estado_d = ESPERA;
          end
        end
      end

      ESPERA: begin
        // Strobes arriving here are dropped and are not queued.
        if (s_espera) begin
          q_d      = 1'b1;
          valido_d = 1'b1;
          exp_d    = 1'b0;
          estado_d = IDLE;
        end else if (cnt_q == '0) begin
          q_d      = 1'b0;
          valido_d = 1'b1;
          exp_d    = 1'b1;
          estado_d = IDLE;
        end else begin
          cnt_d = cnt_q - TIMEOUT_W'(1);
        end
      end

      default: estado_d = IDLE;
    endcase
  end

  assign ocupado = (estado == ESPERA);

endmodule

// File: tb/tb_selector_prueba.sv
// -----------------------------------------------------------------------------
// tb_selector_prueba
// Self-checking bench for selector_prueba. A behavioural model built from the
// selector's rules (input delay line, pending flag, remaining-check count) is
// stepped on every rising edge and compared with the DUT on the falling edge.
// -----------------------------------------------------------------------------
module tb_selector_prueba;

  localparam int N_COND      = 3;
  localparam int SEL_W       = 3;
  localparam int SYNC_STAGES = 2;
  localparam int TIMEOUT_W   = 8;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [N_COND-1:0]    condiciones;
  logic                 interrupcion;
  logic [SEL_W-1:0]     prueba;
  logic                 invertir;
  logic                 evaluar;
  logic                 modo_espera;
  logic [TIMEOUT_W-1:0] limite;
  logic                 ack_int;
  logic                 qseleccionada;
  logic                 valido;
  logic                 ocupado;
  logic                 expirado;
  logic                 int_pendiente;

  selector_prueba #(
    .N_COND      (N_COND),
    .SEL_W       (SEL_W),
    .SYNC_STAGES (SYNC_STAGES),
    .TIMEOUT_W   (TIMEOUT_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .condiciones   (condiciones),
    .interrupcion  (interrupcion),
    .prueba        (prueba),
    .invertir      (invertir),
    .evaluar       (evaluar),
    .modo_espera   (modo_espera),
    .limite        (limite),
    .ack_int       (ack_int),
    .qseleccionada (qseleccionada),
    .valido        (valido),
    .ocupado       (ocupado),
    .expirado      (expirado),
    .int_pendiente (int_pendiente)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  logic [N_COND:0] hist[$];   // raw inputs of the last SYNC_STAGES edges
  bit m_busy;
  int m_checks_left;
  int m_code;
  bit m_inv;
  bit m_q, m_v, m_e, m_pend, m_int_last;

  function automatic bit m_sel(input int code, input bit inv,
                               input logic [N_COND:0] sv, input bit pend);
    logic [N_COND:0] t;
    bit b;
    t = sv >> code;
    if (code < N_COND)       b = t[0];
    else if (code == N_COND) b = pend;
    else                     b = 1'b0;
    return b ^ inv;
  endfunction

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < SYNC_STAGES; i++) hist.push_back('0);
    m_busy = 0; m_checks_left = 0; m_code = 0; m_inv = 0;
    m_q = 0; m_v = 0; m_e = 0; m_pend = 0; m_int_last = 0;
  endtask

  task automatic model_step();
    logic [N_COND:0] sv;
    bit pend_old;
    sv       = hist[0];
    pend_old = m_pend;
    m_v      = 0;
    if (!m_busy) begin
      if (evaluar) begin
        if (!modo_espera) begin
          m_q = m_sel(int'(prueba), invertir, sv, pend_old);
          m_v = 1; m_e = 0;
        end else begin
          m_busy = 1;
          m_code = int'(prueba);
          m_inv  = invertir;
          m_checks_left = int'(limite) + 1;
        end
      end
    end else begin
      if (m_sel(m_code, m_inv, sv, pend_old)) begin
        m_q = 1; m_v = 1; m_e = 0; m_busy = 0;
      end else begin
        m_checks_left--;
        if (m_checks_left == 0) begin
          m_q = 0; m_v = 1; m_e = 1; m_busy = 0;
        end
      end
    end
    if (sv[N_COND] && !m_int_last) m_pend = 1;
    else if (ack_int)              m_pend = 0;
    m_int_last = sv[N_COND];
    void'(hist.pop_front());
    hist.push_back({interrupcion, condiciones});
  endtask

  task automatic compare_all(input string ctx);
    check({ctx, ".q"},        qseleccionada, m_q);
    check({ctx, ".valido"},   valido,        m_v);
    check({ctx, ".ocupado"},  ocupado,       m_busy);
    check({ctx, ".expirado"}, expirado,      m_e);
    check({ctx, ".int_pend"}, int_pendiente, m_pend);
  endtask

  int cycle = 0;

  // One clock: model follows the rising edge, outputs compared at the falling edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    cycle++;
    compare_all($sformatf("cyc%0d", cycle));
  endtask

  task automatic start_wait(input int code, input bit inv, input int lim);
    prueba = SEL_W'(code); invertir = inv; limite = TIMEOUT_W'(lim);
    modo_espera = 1; evaluar = 1;
    tick();
    evaluar = 0; modo_espera = 0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (ocupado && n < 100) begin
      n++;
      tick();
    end
  endtask

  task automatic single_shot(input int code, input bit inv);
    prueba = SEL_W'(code); invertir = inv; modo_espera = 0; evaluar = 1;
    tick();
    evaluar = 0;
  endtask

  int n;
  int pulses;

  initial begin
    rst_n = 0; condiciones = '0; interrupcion = 0; prueba = '0; invertir = 0;
    evaluar = 0; modo_espera = 0; limite = '0; ack_int = 0;
    model_reset();
    @(negedge clk);
    #1 compare_all("reset");
    @(negedge clk);
    rst_n = 1;

    // Single shot
    condiciones = 3'b010;
    repeat (3) tick();
    single_shot(1, 0);
    check("ss_q", qseleccionada, 1);
    check("ss_valido", valido, 1);
    tick();
    check("ss_valido_low", valido, 0);
    single_shot(1, 1);
    check("ss_inv_q", qseleccionada, 0);
    // Back-to-back: one result per cycle
    prueba = 3'd1; evaluar = 1;
    for (int i = 0; i < 4; i++) begin
      invertir = i[0];
      tick();
      check("b2b_valido", valido, 1);
      check("b2b_q", qseleccionada, {31'd0, ~i[0]});
    end
    evaluar = 0;

    // Wait success: condition rises before the 4th edge after capture
    condiciones = 3'b000;
    repeat (3) tick();
    start_wait(2, 0, 10);
    check("ws_ocupado", ocupado, 1);
    n = 0;
    repeat (3) begin tick(); n++; end
    condiciones = 3'b100;
    while (!valido && n < 50) begin tick(); n++; end
    check("ws_latency", n, 4 + SYNC_STAGES);
    check("ws_q", qseleccionada, 1);
    check("ws_expirado", expirado, 0);
    check("ws_ocupado_low", ocupado, 0);

    // Wait timeout, limite=5 then limite=0
    condiciones = 3'b000;
    repeat (3) tick();
    start_wait(0, 0, 5);
    count_busy(n);
    check("wt5_busy_cycles", n, 6);
    check("wt5_valido", valido, 1);
    check("wt5_q", qseleccionada, 0);
    check("wt5_expirado", expirado, 1);
    start_wait(0, 0, 0);
    count_busy(n);
    check("wt0_busy_cycles", n, 1);
    check("wt0_expirado", expirado, 1);

    // Interrupt latency, evaluation, ack vs set
    interrupcion = 1;
    tick(); check("int_e1", int_pendiente, 0);
    tick(); check("int_e2", int_pendiente, 0);
    tick(); check("int_e3", int_pendiente, 1);
    single_shot(3, 0);
    check("int_eval_q", qseleccionada, 1);
    check("int_eval_keeps", int_pendiente, 1);
    interrupcion = 0; ack_int = 1;
    tick();
    ack_int = 0;
    check("int_ack", int_pendiente, 0);
    repeat (3) tick();
    interrupcion = 1;
    tick(); tick();
    ack_int = 1;
    tick();
    ack_int = 0;
    check("int_ack_vs_set", int_pendiente, 1);
    ack_int = 1;
    tick();
    ack_int = 0;
    check("int_ack_alone", int_pendiente, 0);
    interrupcion = 0;
    repeat (3) tick();

    // Constant code
    single_shot(7, 0);
    check("const_q0", qseleccionada, 0);
    single_shot(7, 1);
    check("const_q1", qseleccionada, 1);

    // evaluar while busy is ignored
    start_wait(0, 0, 3);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      prueba = 3'd7; invertir = 1; modo_espera = 0; evaluar = (i < 2);
      tick();
      if (valido) pulses++;
    end
    evaluar = 0;
    check("busy_ignore_pulses", pulses, 1);
    check("busy_ignore_q", qseleccionada, 0);
    check("busy_ignore_exp", expirado, 1);

    // Reset in the middle of a wait
    interrupcion = 1;
    repeat (3) tick();
    interrupcion = 0;
    start_wait(0, 0, 20);
    tick(); tick();
    #2 rst_n = 0;
    model_reset();
    #1;
    check("rst_q", qseleccionada, 0);
    check("rst_valido", valido, 0);
    check("rst_ocupado", ocupado, 0);
    check("rst_expirado", expirado, 0);
    check("rst_int_pend", int_pendiente, 0);
    @(negedge clk);
    rst_n = 1;
    pulses = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (valido) pulses++;
    end
    check("rst_no_valido", pulses, 0);

    // Randomised traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) condiciones = N_COND'($urandom);
      if ($urandom_range(0, 7) == 0) interrupcion = ~interrupcion;
      prueba      = SEL_W'($urandom_range(0, 7));
      invertir    = 1'($urandom);
      evaluar     = ($urandom_range(0, 2) == 0);
      modo_espera = 1'($urandom);
      limite      = TIMEOUT_W'($urandom_range(0, 6));
      ack_int     = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 499) == 0) begin
        #2 rst_n = 0;
        model_reset();
        #1 compare_all("rnd_reset");
        @(negedge clk);
        rst_n = 1;
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
